// File: rtl/minimig_autoconfig_host_pkg.sv
// Shared Autoconfig constants: config-space offsets, pool bounds, type codes and host FSM states.
// No logic; imported by the host and its size decoder.
package minimig_autoconfig_host_pkg;

    localparam logic [7:0] OFS_TYPE_HI    = 8'h00;
    localparam logic [7:0] OFS_TYPE_LO    = 8'h02;
    localparam logic [7:0] OFS_Z3_BASE    = 8'h44;
    localparam logic [7:0] OFS_Z2_BASE_HI = 8'h48;
    localparam logic [7:0] OFS_Z2_BASE_LO = 8'h4A;
    localparam logic [7:0] OFS_SHUTUP     = 8'h4C;

    localparam logic [23:0] Z2_POOL_START = 24'h200000;
    localparam logic [23:0] Z2_POOL_END   = 24'hA00000;
    localparam logic [31:0] Z3_POOL_START = 32'h40000000;
    localparam logic [31:0] Z3_POOL_END   = 32'h80000000;

    localparam logic [1:0] TYPE_Z2 = 2'b11;
    localparam logic [1:0] TYPE_Z3 = 2'b10;

    localparam logic [4:0] Z2_LOG2_8M   = 5'd23;
    localparam logic [4:0] Z2_LOG2_BASE = 5'd15;
    localparam logic [4:0] Z3_LOG2_BASE = 5'd24;
    localparam logic [3:0] MAX_BOARDS   = 4'd8;

    typedef enum logic [3:0] {
        IDLE, RD_T0, RD_T1, DECODE, WR_Z2LO, WR_Z2HI, WR_Z3, WR_SHUT, NEXT, DONE
    } state_t;

    // Byte offsets in config space map to bus word addresses [8:1].
    function automatic logic [7:0] word_addr(input logic [7:0] ofs);
        return ofs >> 1;
    endfunction

endpackage

// File: rtl/minimig_autoconfig_host_size_decode.sv
// Combinational Autoconfig type decode: board class and log2 size, with a legality flag.
// Zero latency; no flow control.
module autoconfig_size_decode
    import minimig_autoconfig_host_pkg::*;
(
    input  logic [7:0] type_code,
    output logic       z3,
    output logic [4:0] size_log2,
    output logic       valid
);

    logic unused_type_bits;
    assign unused_type_bits = ^type_code[5:3];

    always_comb begin
        z3        = (type_code[7:6] == TYPE_Z3);
        valid     = 1'b0;
        size_log2 = 5'd0;
        if (type_code[7:6] == TYPE_Z2) begin
            valid     = 1'b1;
            size_log2 = (type_code[2:0] == 3'd0) ? Z2_LOG2_8M
                                                 : Z2_LOG2_BASE + {2'b00, type_code[2:0]};
        end else if (z3) begin
            // Code 7 would be 2G, larger than the whole Zorro III pool.
            valid     = (type_code[2:0] != 3'd7);
            size_log2 = Z3_LOG2_BASE + {2'b00, type_code[2:0]};
        end
    end

endmodule

// File: rtl/minimig_autoconfig_host.sv
// Autoconfig host: walks the board chain, reads type nibbles, assigns aligned bases or shuts boards up.
// Bus phases advance only on clk7_en ticks (read 2+1 ticks, write 1+1 ticks); start is ignored while busy.
module minimig_autoconfig_host
    import minimig_autoconfig_host_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        start,
    output logic [7:0]  address_out,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    output logic        sel,
    output logic        rd,
    output logic        hwr,
    output logic        lwr,
    output logic        cfg_valid,
    output logic [15:0] cfg_base,
    output logic [4:0]  cfg_size_log2,
    output logic        cfg_z3,
    output logic        cfg_shutup,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  board_count
);

    state_t      state;
    logic [1:0]  ph;
    logic [7:0]  type_reg;
    logic [23:0] next_z2;
    logic [31:0] next_z3;
    logic        start_pend;

    logic        dec_z3;
    logic [4:0]  dec_log2;
    logic        dec_valid;
    logic        present;

    autoconfig_size_decode u_size_decode (
        .type_code (type_reg),
        .z3        (dec_z3),
        .size_log2 (dec_log2),
        .valid     (dec_valid)
    );

    assign present = (type_reg[7:6] == TYPE_Z2) || (type_reg[7:6] == TYPE_Z3);

    // Wide enough that base+size of the largest board never wraps.
    logic [33:0] ptr, pool_end, size, base, base_end;
    logic        fits;

    always_comb begin
        ptr      = dec_z3 ? {2'b00, next_z3} : {10'd0, next_z2};
        pool_end = dec_z3 ? {2'b00, Z3_POOL_END} : {10'd0, Z2_POOL_END};
        size     = 34'd1 << dec_log2;
        base     = (ptr + size - 34'd1) & ~(size - 34'd1);
        base_end = base + size;
        fits     = dec_valid && (base_end <= pool_end);
    end

    logic unused_bits;
    assign unused_bits = ^{data_in[11:0], base[33:32], base[15:0], base_end[33:32]};

    always_ff @(posedge clk) begin
        cfg_valid <= 1'b0;
        if (reset) begin
            state         <= IDLE;
            ph            <= 2'd0;
            type_reg      <= 8'h00;
            next_z2       <= Z2_POOL_START;
            next_z3       <= Z3_POOL_START;
            start_pend    <= 1'b0;
            address_out   <= 8'h00;
            data_out      <= 16'h0000;
            sel           <= 1'b0;
            rd            <= 1'b0;
            hwr           <= 1'b0;
            lwr           <= 1'b0;
            cfg_base      <= 16'h0000;
            cfg_size_log2 <= 5'd0;
            cfg_z3        <= 1'b0;
            cfg_shutup    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            board_count   <= 4'd0;
        end else begin
            // A start landing between ticks is held until the next tick.
            if (start && (state == IDLE || state == DONE))
                start_pend <= 1'b1;

            if (clk7_en) begin
                case (state)
                    IDLE, DONE: begin
                        if (start || start_pend) begin
                            start_pend  <= 1'b0;
                            done        <= 1'b0;
                            error       <= 1'b0;
                            board_count <= 4'd0;
                            next_z2     <= Z2_POOL_START;
                            next_z3     <= Z3_POOL_START;
                            busy        <= 1'b1;
                            ph          <= 2'd0;
                            state       <= RD_T0;
                            sel         <= 1'b1;
                            rd          <= 1'b1;
                            address_out <= word_addr(OFS_TYPE_HI);
                        end
                    end

                    // Each bus cycle is launched on the edge that enters its state.
                    RD_T0, RD_T1: begin
                        ph <= ph + 2'd1;
                        if (ph == 2'd1) begin
                            sel <= 1'b0;
                            rd  <= 1'b0;
                            if (state == RD_T0)
                                type_reg[7:4] <= data_in[15:12];
                            else
                                type_reg[3:0] <= data_in[15:12];
                        end
                        if (ph == 2'd2) begin
                            ph <= 2'd0;
                            if (state == RD_T0) begin
                                state       <= RD_T1;
                                sel         <= 1'b1;
                                rd          <= 1'b1;
                                address_out <= word_addr(OFS_TYPE_LO);
                            end else begin
                                state <= DECODE;
                            end
                        end
                    end

                    DECODE: begin
                        ph <= 2'd0;
                        if (!present) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (board_count == MAX_BOARDS) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cfg_z3        <= dec_z3;
                            cfg_size_log2 <= dec_log2;
                            sel           <= 1'b1;
                            if (!fits) begin
                                cfg_shutup  <= 1'b1;
                                cfg_base    <= 16'h0000;
                                state       <= WR_SHUT;
                                hwr         <= 1'b1;
                                address_out <= word_addr(OFS_SHUTUP);
                                data_out    <= 16'h0000;
                            end else if (dec_z3) begin
                                cfg_shutup  <= 1'b0;
                                cfg_base    <= base[31:16];
                                next_z3     <= base_end[31:0];
                                state       <= WR_Z3;
                                hwr         <= 1'b1;
                                lwr         <= 1'b1;
                                address_out <= word_addr(OFS_Z3_BASE);
                                data_out    <= base[31:16];
                            end else begin
                                cfg_shutup  <= 1'b0;
                                cfg_base    <= base[31:16];
                                next_z2     <= base_end[23:0];
                                state       <= WR_Z2LO;
                                lwr         <= 1'b1;
                                address_out <= word_addr(OFS_Z2_BASE_LO);
                                data_out    <= {base[19:16], 12'h000};
                            end
                        end
                    end

                    WR_Z2LO, WR_Z2HI, WR_Z3, WR_SHUT: begin
                        if (ph == 2'd0) begin
                            ph       <= 2'd1;
                            sel      <= 1'b0;
                            hwr      <= 1'b0;
                            lwr      <= 1'b0;
                            data_out <= 16'h0000;
                        end else begin
                            ph <= 2'd0;
                            // The high nibble must land last: that write configures a Zorro II board.
                            if (state == WR_Z2LO) begin
                                state       <= WR_Z2HI;
                                sel         <= 1'b1;
                                hwr         <= 1'b1;
                                address_out <= word_addr(OFS_Z2_BASE_HI);
                                data_out    <= {cfg_base[7:4], 12'h000};
                            end else begin
                                state <= NEXT;
                            end
                        end
                    end

                    NEXT: begin
                        cfg_valid   <= 1'b1;
                        board_count <= board_count + 4'd1;
                        ph          <= 2'd0;
                        state       <= RD_T0;
                        sel         <= 1'b1;
                        rd          <= 1'b1;
                        address_out <= word_addr(OFS_TYPE_HI);
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_minimig_autoconfig_host.sv
// Bench for the Autoconfig host: a config-space responder plays a board chain and a reference
// allocator predicts every bus write, cfg pulse and final status.
module tb_minimig_autoconfig_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk7_en = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  address_out;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        sel, rd, hwr, lwr, cfg_valid;
    logic [15:0] cfg_base;
    logic [4:0]  cfg_size_log2;
    logic        cfg_z3, cfg_shutup, busy, done, error;
    logic [3:0]  board_count;

    minimig_autoconfig_host dut (
        .clk           (clk),
        .reset         (reset),
        .clk7_en       (clk7_en),
        .start         (start),
        .address_out   (address_out),
        .data_out      (data_out),
        .data_in       (data_in),
        .sel           (sel),
        .rd            (rd),
        .hwr           (hwr),
        .lwr           (lwr),
        .cfg_valid     (cfg_valid),
        .cfg_base      (cfg_base),
        .cfg_size_log2 (cfg_size_log2),
        .cfg_z3        (cfg_z3),
        .cfg_shutup    (cfg_shutup),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .board_count   (board_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tick enable: one clk in `period`.
    int period = 1;
    int tick_cnt = 0;
    always @(posedge clk) begin
        #1;
        tick_cnt = (tick_cnt + 1 >= period) ? 0 : tick_cnt + 1;
        clk7_en  = (tick_cnt == 0);
    end

    function automatic logic [63:0] outs();
        return {5'd0, address_out, data_out, sel, rd, hwr, lwr, cfg_valid, cfg_base,
                cfg_size_log2, cfg_z3, cfg_shutup, busy, done, error, board_count};
    endfunction

    // Config-space responder: the head of chain_q answers until it is configured or shut up.
    logic [7:0] chain_q[$];
    logic [7:0] cur_type = 8'h00;
    logic [7:0] boards[16];

    always_comb begin
        data_in = 16'h5A5A;
        if (sel && rd)
            data_in = (address_out == 8'h00) ? {cur_type[7:4], 12'h3C5} : {cur_type[3:0], 12'h3C5};
    end

    typedef struct packed {logic [7:0] addr; logic [15:0] dat; logic [1:0] strb;} wr_t;
    typedef struct packed {logic [15:0] base; logic [4:0] log2; logic z3; logic shutup;} cfg_t;
    wr_t  exp_wr[$];
    cfg_t exp_cfg[$];
    logic exp_err;
    int   exp_cnt;

    // Reference allocator working in byte addresses with divide-based rounding.
    task automatic build_model(input int n);
        longint nz2 = 64'h200000, nz3 = 64'h40000000;
        longint sz, base, lim, ptr;
        int cnt = 0, lg;
        logic [7:0] t;
        bit z3, ok;
        exp_wr.delete(); exp_cfg.delete(); exp_err = 1'b0;
        for (int i = 0; i <= n; i++) begin
            t = (i < n) ? boards[i] : 8'h00;
            if (t[7:6] != 2'b11 && t[7:6] != 2'b10) break;
            if (cnt == 8) begin exp_err = 1'b1; break; end
            z3 = (t[7:6] == 2'b10);
            if (z3) begin
                lg = 24 + int'(t[2:0]); ok = (t[2:0] != 3'd7); ptr = nz3; lim = 64'h80000000;
            end else begin
                lg = (t[2:0] == 3'd0) ? 23 : 15 + int'(t[2:0]); ok = 1; ptr = nz2; lim = 64'hA00000;
            end
            sz   = 64'd1 << lg;
            base = ((ptr + sz - 1) / sz) * sz;
            if (ok && base + sz <= lim) begin
                exp_cfg.push_back('{16'(base >> 16), 5'(lg), z3, 1'b0});
                if (z3) begin
                    exp_wr.push_back('{8'h22, 16'(base >> 16), 2'b11});
                    nz3 = base + sz;
                end else begin
                    exp_wr.push_back('{8'h25, 16'(((base >> 16) & 15) << 12), 2'b01});
                    exp_wr.push_back('{8'h24, 16'(((base >> 20) & 15) << 12), 2'b10});
                    nz2 = base + sz;
                end
            end else begin
                exp_cfg.push_back('{16'h0000, 5'(lg), z3, 1'b1});
                exp_wr.push_back('{8'h26, 16'h0000, 2'b10});
            end
            cnt++;
        end
        exp_cnt = cnt;
    endtask

    // Bus monitor: cycle shape, writes and cfg pulses, sampled on the falling edge.
    int   run_clks = 0, run_ticks = 0, gap_ticks = 0;
    logic run_rd = 1'b0, prev_rd = 1'b0, saw_z2hi = 1'b0;
    logic [7:0] run_addr = 8'h00, prev_addr = 8'hFF;
    wr_t  e_wr;
    cfg_t e_cfg;

    always @(negedge clk) begin
        if (reset) begin
            run_clks = 0; run_ticks = 0; gap_ticks = 0; prev_addr = 8'hFF;
        end else begin
            if (sel) begin
                if (run_clks == 0) begin
                    run_rd = rd; run_addr = address_out;
                    if ((rd && address_out == 8'h01 && prev_rd && prev_addr == 8'h00) ||
                        (!rd && address_out == 8'h24 && prev_addr == 8'h25))
                        check("gap_ticks", gap_ticks, 1);
                end
                run_clks++;
                if (clk7_en) run_ticks++;
            end else begin
                if (run_clks > 0) begin
                    check(run_rd ? "rd_ticks" : "wr_ticks", run_ticks, run_rd ? 2 : 1);
                    check("run_clks", run_clks, run_ticks * period);
                    prev_addr = run_addr; prev_rd = run_rd;
                    run_clks = 0; run_ticks = 0; gap_ticks = 0;
                end
                if (clk7_en) gap_ticks++;
            end
            if (clk7_en && !hwr && !lwr)
                check("data_idle", data_out, 0);
            if (sel && clk7_en && (hwr || lwr)) begin
                if (exp_wr.size() == 0) begin
                    check("wr_extra", {address_out, data_out, hwr, lwr}, 0);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("wr_addr", address_out, e_wr.addr);
                    check("wr_data", data_out, e_wr.dat);
                    check("wr_strb", {hwr, lwr}, e_wr.strb);
                end
                if (address_out == 8'h24) saw_z2hi = 1'b1;
                if (address_out == 8'h22 || address_out == 8'h24 || address_out == 8'h26) begin
                    if (chain_q.size() > 0) void'(chain_q.pop_front());
                    cur_type = (chain_q.size() > 0) ? chain_q[0] : 8'h00;
                end
            end
            if (cfg_valid) begin
                if (exp_cfg.size() == 0) begin
                    check("cfg_extra", cfg_valid, 0);
                end else begin
                    e_cfg = exp_cfg.pop_front();
                    check("cfg_base", cfg_base, e_cfg.base);
                    check("cfg_log2", cfg_size_log2, e_cfg.log2);
                    check("cfg_z3", cfg_z3, e_cfg.z3);
                    check("cfg_shutup", cfg_shutup, e_cfg.shutup);
                end
            end
        end
    end

    task automatic load_chain(input int n);
        chain_q.delete();
        for (int i = 0; i < n; i++) chain_q.push_back(boards[i]);
        cur_type = (n > 0) ? boards[0] : 8'h00;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_chain(input int n, input int per, input bit poke_start);
        int w;
        period = per;
        load_chain(n);
        build_model(n);
        pulse_start();
        w = 0;
        while (!busy && w < 2000) begin @(posedge clk); #1; w++; end
        check("busy_rise", busy, 1);
        if (poke_start) begin
            repeat (7) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        w = 0;
        while (busy && w < 20000) begin @(posedge clk); #1; w++; end
        check("busy_fall", busy, 0);
        repeat (10) @(posedge clk);
        #1;
        check("done", done, 1);
        check("error", error, exp_err);
        check("board_count", board_count, exp_cnt);
        check("busy_idle", busy, 0);
        check("wr_left", exp_wr.size(), 0);
        check("cfg_left", exp_cfg.size(), 0);
        exp_wr.delete(); exp_cfg.delete();
    endtask

    function automatic logic [7:0] rand_board();
        int r;
        logic [7:0] t;
        r = $urandom_range(0, 9);
        t = 8'($urandom);
        if (r < 6) t[7:6] = 2'b11;
        else if (r < 9) t[7:6] = 2'b10;
        return t;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", outs(), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_outs", outs(), 0);

        boards[0] = 8'hE7;
        run_chain(1, 1, 0);
        boards[0] = 8'hE6; boards[1] = 8'hA1; boards[2] = 8'hA0;
        run_chain(3, 1, 0);
        boards[0] = 8'hE7; boards[1] = 8'hE0;
        run_chain(2, 1, 0);
        boards[0] = 8'hA7; boards[1] = 8'hC3;
        run_chain(2, 2, 0);
        for (int i = 0; i < 9; i++) boards[i] = {2'b11, 6'($urandom)};
        run_chain(9, 1, 0);
        boards[0] = 8'hE6; boards[1] = 8'hA1;
        run_chain(2, 4, 1);

        for (int s = 0; s < 16; s++) begin
            int n;
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) boards[i] = rand_board();
            run_chain(n, $urandom_range(1, 4), 0);
        end

        // Reset while the Zorro II high-nibble write is on the bus but before its tick.
        period = 4;
        boards[0] = 8'hE6;
        load_chain(1);
        build_model(1);
        saw_z2hi = 1'b0;
        pulse_start();
        w = 0;
        while (!(hwr && address_out == 8'h24) && w < 2000) begin @(posedge clk); #1; w++; end
        check("z2hi_reached", hwr, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outs", outs(), 0);
        check("rst_mid_strobes", {sel, rd, hwr, lwr}, 0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_z2hi", saw_z2hi, 0);
        check("rst_quiet", {sel, busy}, 0);
        exp_wr.delete(); exp_cfg.delete();

        boards[0] = 8'hE5;
        run_chain(1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
